// File: rtl/mmio_responder.sv
// mmio_responder
// --------------
// A memory-mapped peripheral in a 16-byte window at BASE. It sits on the CPU bus
// alongside cpumemory. Reads have a one-cycle registered latency, which is the same
// latency that cpumemory has. It holds the following state:
//   - a 16-bit LED register
//   - an 8-bit TIMER, advanced by a prescaler, with an 8-bit compare (CMP)
//   - a sticky match flag
//   - an interrupt line
//
// Ports:
//   clk      : system clock. All state changes on the rising edge.
//   reset    : asynchronous, active-high. Clears all state.
//   addr     : bus address. A hit is decoded when addr[15:4] == BASE[15:4].
//   data_in  : write data.
//   mw       : write strobe. A write happens on an edge where mw=1 and addr hits.
//   data_out : registered read data. It is 8'h00 when the previous cycle did not hit.
//   hit      : registered decode. The CPU top uses it to select this read data.
//   led      : LED register contents.
//   irq      : flag & CTRL.irq_en. Combinational from registers.
//
// Register map (offset addr[3:0]):
//   0 LED_LO rw | 1 LED_HI rw | 2 TIMER rw | 3 CMP rw | 4 STATUS (bit0 flag, W1C)
//   5 CTRL rw[2:0] = {irq_en, auto_reload, enable} | 6 ID ro | 7-15 read 0
module mmio_responder #(
  parameter logic [15:0] BASE     = 16'hFF00,
  parameter int          PRESCALE = 1000,
  parameter logic [7:0]  DEV_ID   = 8'h65
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        mw,
  output logic [7:0]  data_out,
  output logic        hit,
  output logic [15:0] led,
  output logic        irq
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [7:0]  data_out_q, data_out_d;
  logic        hit_q;
  logic [15:0] led_q, led_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  cmp_q, cmp_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        flag_q, flag_d;
  logic [15:0] presc_q, presc_d;

  logic       sel;
  logic [3:0] off;
  logic       wr;
  logic       timer_wr;
  logic       tick;
  logic       match;
  logic [7:0] rd_data;

  assign sel      = (addr[15:4] == BASE[15:4]);
  assign off      = addr[3:0];
  assign wr       = mw & sel;
  assign timer_wr = wr & (off == 4'd2);
  assign tick     = ctrl_q[0] & (presc_q == PRESC_MAX);
  assign match    = (timer_q == cmp_q);

  // Read mux. It reads the current register values, so a read returns the
  // value from before any write or tick that happens on the same edge.
  always_comb begin
    rd_data = 8'h00;
    case (off)
      4'd0:    rd_data = led_q[7:0];
      4'd1:    rd_data = led_q[15:8];
      4'd2:    rd_data = timer_q;
      4'd3:    rd_data = cmp_q;
      4'd4:    rd_data = {7'd0, flag_q};
      4'd5:    rd_data = {5'd0, ctrl_q};
      4'd6:    rd_data = DEV_ID;
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    data_out_d = sel ? rd_data : 8'h00;
    led_d      = led_q;
    cmp_d      = cmp_q;
    ctrl_d     = ctrl_q;
    timer_d    = timer_q;
    flag_d     = flag_q;
    presc_d    = presc_q;

    if (wr && off == 4'd0) led_d[7:0]  = data_in;
    if (wr && off == 4'd1) led_d[15:8] = data_in;
    if (wr && off == 4'd3) cmp_d       = data_in;
    if (wr && off == 4'd5) ctrl_d      = data_in[2:0];

    // The prescaler advances only while the timer is enabled.
    if (ctrl_q[0]) begin
      presc_d = (presc_q == PRESC_MAX) ? 16'd0 : presc_q + 16'd1;
    end

    // The compare uses the old CMP even when CMP is written on this edge.
    if (tick && match) begin
      timer_d = ctrl_q[1] ? 8'h00 : timer_q + 8'd1;
    end else if (tick) begin
      timer_d = timer_q + 8'd1;
    end

    // Writing 1 to STATUS bit0 clears the flag. If a match sets the flag on the
    // same edge, the set takes priority.
    if (wr && off == 4'd4 && data_in[0]) flag_d = 1'b0;
    if (tick && match)                    flag_d = 1'b1;

    // A TIMER write cancels this edge's tick completely: no count, no flag
    // change from the tick, and the prescaler starts its period again.
    if (timer_wr) begin
      timer_d = data_in;
      presc_d = 16'd0;
      flag_d  = flag_q;
      if (off == 4'd4 && data_in[0]) flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= 8'h00;
      hit_q      <= 1'b0;
      led_q      <= 16'h0000;
      timer_q    <= 8'h00;
      cmp_q      <= 8'hFF;
      ctrl_q     <= 3'b000;
      flag_q     <= 1'b0;
      presc_q    <= 16'd0;
    end else begin
      data_out_q <= data_out_d;
      hit_q      <= sel;
      led_q      <= led_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      ctrl_q     <= ctrl_d;
      flag_q     <= flag_d;
      presc_q    <= presc_d;
    end
  end

  assign data_out = data_out_q;
  assign hit      = hit_q;
  assign led      = led_q;
  assign irq      = flag_q & ctrl_q[2];

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

  localparam int PS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        mw;
  logic [7:0]  data_out;
  logic        hit;
  logic [15:0] led;
  logic        irq;

  mmio_responder #(.BASE(16'hFF00), .PRESCALE(PS), .DEV_ID(8'h65)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .mw(mw),
    .data_out(data_out), .hit(hit), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of the peripheral, using plain integers.
  int m_led, m_timer, m_cmp, m_ctrl, m_flag, m_presc, m_dout, m_hit;

  task automatic model_reset();
    m_led = 0; m_timer = 0; m_cmp = 255; m_ctrl = 0; m_flag = 0;
    m_presc = 0; m_dout = 0; m_hit = 0;
  endtask

  task automatic model_step(input int a, input int d, input int w);
    int  off, rd;
    bit  h, ticked, matched, twr, wen;
    h       = (a / 16) == (16'hFF00 / 16);
    off     = a % 16;
    wen     = h && (w != 0);
    twr     = wen && off == 2;
    ticked  = (m_ctrl % 2 == 1) && (m_presc == PS - 1) && !twr;
    matched = (m_timer == m_cmp);
    case (off)
      0: rd = m_led % 256;
      1: rd = m_led / 256;
      2: rd = m_timer;
      3: rd = m_cmp;
      4: rd = m_flag;
      5: rd = m_ctrl;
      6: rd = 'h65;
      default: rd = 0;
    endcase
    m_dout = h ? rd : 0;
    m_hit  = h;
    // Advance the prescaler and timer first, then apply the bus write.
    if (m_ctrl % 2 == 1) m_presc = (m_presc + 1) % PS;
    if (ticked) begin
      if (matched && ((m_ctrl / 2) % 2 == 1)) m_timer = 0;
      else m_timer = (m_timer + 1) % 256;
    end
    if (wen && off == 4 && d % 2 == 1) m_flag = 0;
    if (ticked && matched) m_flag = 1;
    if (wen) begin
      case (off)
        0: m_led = (m_led / 256) * 256 + d;
        1: m_led = d * 256 + m_led % 256;
        2: begin m_timer = d; m_presc = 0; end
        3: m_cmp = d;
        5: m_ctrl = d % 8;
        default: ;
      endcase
    end
  endtask

  function automatic int m_irq();
    return (m_flag == 1 && m_ctrl / 4 == 1) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("data_out", int'(data_out), m_dout);
    chk("hit", int'(hit), m_hit);
    chk("led", int'(led), m_led);
    chk("irq", int'(irq), m_irq());
  endtask

  // Drive one bus cycle, step the model at the edge, then compare just after the edge.
  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic w);
    addr = a; data_in = d; mw = w;
    model_step(int'(a), int'(d), int'(w));
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(16'h0000, 8'h00, 1'b0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic [7:0]  exp_dout;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{16'hFF00, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{16'hFF01, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{16'hFF02, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{16'hFF03, 8'h00, 1'b0, 8'hFF, 1'b1};
    vecs[4]  = '{16'hFF04, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{16'hFF05, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[6]  = '{16'hFF06, 8'h00, 1'b0, 8'h65, 1'b1};
    vecs[7]  = '{16'hFF07, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[8]  = '{16'h0002, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{16'hFF00, 8'hA5, 1'b1, 8'h00, 1'b1};
    vecs[10] = '{16'hFF01, 8'h3C, 1'b1, 8'h00, 1'b1};
    vecs[11] = '{16'hFF00, 8'h00, 1'b0, 8'hA5, 1'b1};
    vecs[12] = '{16'hFF01, 8'h00, 1'b0, 8'h3C, 1'b1};
    vecs[13] = '{16'hFF0A, 8'h77, 1'b1, 8'h00, 1'b1};
    vecs[14] = '{16'hFF0A, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[15] = '{16'hFF12, 8'h55, 1'b1, 8'h00, 1'b0};

    addr = 16'h0000; data_in = 8'h00; mw = 1'b0; reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_irq", int'(irq), 0);
    reset = 1'b0;

    // Table-driven reset readback, LED writes and out-of-window accesses.
    for (int i = 0; i < 16; i++) begin
      addr = vecs[i].a; data_in = vecs[i].d; mw = vecs[i].w;
      model_step(int'(vecs[i].a), int'(vecs[i].d), int'(vecs[i].w));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_dout", i), int'(data_out), int'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_hit", i), int'(hit), int'(vecs[i].exp_hit));
      chk_model();
      if (i == 10) chk("led_3CA5", int'(led), 'h3CA5);
    end
    chk("led_after_ignored_writes", int'(led), 'h3CA5);

    // Compare, auto-reload and irq. The TIMER write clears the prescaler, so
    // ticks fall on the 4th, 8th and 12th edges after it.
    bus(16'hFF03, 8'h02, 1'b1);
    bus(16'hFF05, 8'h07, 1'b1);
    bus(16'hFF02, 8'h00, 1'b1);
    idle(11);
    chk("irq_before_match", int'(irq), 0);
    idle(1);
    chk("irq_on_match", int'(irq), 1);
    bus(16'hFF02, 8'h00, 1'b0);
    chk("timer_reloaded", int'(data_out), 0);
    bus(16'hFF04, 8'h01, 1'b1);
    chk("irq_cleared", int'(irq), 0);
    // The previous two edges were 13 and 14. The next match tick is edge 24.
    idle(9);
    bus(16'hFF04, 8'h01, 1'b1);
    chk("set_beats_clear", int'(irq), 1);

    // A TIMER write on a tick edge. Edges 25..27 have no tick, and edge 28 ticks.
    // Write at 28. The next increment is 4 edges later.
    idle(3);
    bus(16'hFF02, 8'h10, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      bus(16'hFF02, 8'h00, 1'b0);
      chk($sformatf("timer_hold_%0d", k), int'(data_out), 'h10);
    end
    bus(16'hFF02, 8'h00, 1'b0);
    chk("timer_inc_after_write", int'(data_out), 'h11);

    // auto_reload=0: the timer counts through CMP and wraps 255 -> 0.
    bus(16'hFF04, 8'h01, 1'b1);
    bus(16'hFF05, 8'h05, 1'b1);
    bus(16'hFF02, 8'hFD, 1'b1);
    idle(4 * 6);
    bus(16'hFF02, 8'h00, 1'b0);
    chk("timer_past_cmp", int'(data_out), 3);

    // Random traffic, checked on every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ra;
      logic [7:0]  rd;
      logic        rw;
      ra = ($urandom_range(0, 9) < 8) ? (16'hFF00 | 16'($urandom_range(0, 15)))
                                       : 16'($urandom);
      rd = 8'($urandom);
      if (ra == 16'hFF05 && $urandom_range(0, 3) != 0) rd[0] = 1'b1;
      if (ra == 16'hFF02 && $urandom_range(0, 3) != 0) ra = 16'hFF03;
      rw = ($urandom_range(0, 9) < 3);
      bus(ra, rd, rw);
    end

    // Asynchronous reset in the middle of operation.
    bus(16'hFF00, 8'hFF, 1'b1);
    bus(16'hFF01, 8'hFF, 1'b1);
    bus(16'hFF03, 8'h00, 1'b1);
    bus(16'hFF05, 8'h07, 1'b1);
    bus(16'hFF02, 8'h00, 1'b1);
    idle(4);
    chk("pre_reset_irq", int'(irq), 1);
    chk("pre_reset_led", int'(led), 'hFFFF);
    bus(16'hFF04, 8'h00, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_data_out", int'(data_out), 0);
    chk("async_hit", int'(hit), 0);
    chk("async_led", int'(led), 0);
    chk("async_irq", int'(irq), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus(16'hFF03, 8'h00, 1'b0);
    chk("cmp_after_reset", int'(data_out), 'hFF);
    bus(16'hFF06, 8'h00, 1'b0);
    chk("id_after_reset", int'(data_out), 'h65);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
Memory-mapped peripheral that responds to CPU bus cycles alongside cpumemory. It decodes a 16-byte window, serves reads with the same one-cycle registered latency as cpumemory, and accepts writes when mw is asserted. It contains a 16-bit LED output register, an 8-bit prescaled timer with compare, a sticky match flag and an interrupt request line. The CPU top muxes its read data against cpumemory using the registered hit output.

Parameters:
BASE, 16'hFF00, window base; hit when addr[15:4] == BASE[15:4]
PRESCALE, 1000, clk cycles per timer tick (legal range 1..65535)
DEV_ID, 8'h65, constant value returned by the ID register

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
addr  input  16  bus address (memmux output)
data_in  input  8  write data
mw  input  1  memory write strobe; a write occurs on a cycle with mw=1 and hit
data_out  output  8  registered read data
hit  output  1  registered; high the cycle after a decoded access
led  output  16  LED register contents, drives the ledctrl instances
irq  output  1  flag & CTRL.irq_en (combinational from registers)

Behaviour:
- Reset values: data_out=0, hit=0, led=0, TIMER=0, CMP=8'hFF, CTRL=0, flag=0, prescaler=0.
- Register map (offset addr[3:0]):
  0 LED_LO: rw, led[7:0]
  1 LED_HI: rw, led[15:8]
  2 TIMER: rw; a write loads the counter and clears the prescaler
  3 CMP: rw
  4 STATUS: bit0 = flag; writing 1 to bit0 clears it; other bits read 0
  5 CTRL: rw bits[2:0]; bit0 enable, bit1 auto_reload, bit2 irq_en; bits[7:3] read 0
  6 ID: ro, returns DEV_ID
  7-15: read 8'h00, writes ignored
- Read: on each edge, data_out <= selected register if hit else 8'h00, and hit <= decoded hit. Latency is exactly 1 cycle. A read of the same address on consecutive cycles returns the value as it was before that edge's update.
- Write: takes effect on the edge where mw=1 and the address decodes. data_out on that edge returns the pre-write value.
- Prescaler: counts 0..PRESCALE-1 while enable=1, then wraps to 0. tick = enable & (prescaler == PRESCALE-1). When enable=0, the prescaler and TIMER both hold.
- On tick:
  - If TIMER == CMP: set flag; TIMER <= 0 if auto_reload, else TIMER+1.
  - Otherwise TIMER <= TIMER+1.
  - TIMER wraps 255 -> 0 modulo 256 with no flag unless CMP matched.
- Simultaneous events:
  - A TIMER write on a tick cycle: the write wins and the tick is discarded.
  - Flag set and write-1-clear on the same edge: set wins, flag=1.
  - A CMP write on a tick cycle: the compare uses the old CMP.
- irq follows flag & irq_en with no extra delay.
- Reset asserted mid-operation: all state clears immediately. The first access after deassertion behaves as after power-on.

Test Plan:
- Reset, then read offsets 0..7 -> data_out one cycle later is 00,00,00,FF,00,00,65,00; hit=1 on each read; reading addr 16'h0002 -> hit=0, data_out=0.
- Write 8'hA5 to FF00 and 8'h3C to FF01 -> led=16'h3CA5 on the edge after the write; readback returns A5 then 3C; a write to FF0A leaves all state unchanged.
- PRESCALE=4, CMP=2, CTRL=3'b111 -> TIMER sequence 0,1,2,0 with one tick every 4 clocks; flag and irq rise on the tick where TIMER==2; with auto_reload=0, TIMER continues to 3 and wraps 255 -> 0.
- With flag=1, write STATUS=8'h01 -> flag=0 and irq=0 next cycle; the same write on a matching tick cycle -> flag stays 1.
- Write TIMER=8'h10 on a tick cycle -> TIMER=8'h10 and the prescaler restarts from 0; the next increment occurs PRESCALE cycles later.
- Assert reset mid-count with led=FFFF, flag=1 -> all outputs are 0 immediately (asynchronous); after release, CMP reads back FF.
